// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
//   ID/EX pipeline register of an in-order RISC-V style core. It stores the
//   decoded instruction's control bundles, register addresses and operand
//   data for one cycle. It also flags a load-use hazard against the
//   instruction currently in ID.
//
//   Parameters
//     N   datapath width (immediate, instruction word, register data)
//     RW  register-address width
//
//   Ports
//     clk, rst                 rising-edge clock, synchronous active-high reset
//     stall                    hold every stored field
//     flush                    write a bubble (NOP); takes priority over stall
//     valid_in                 ID instruction valid
//     EX_in/MEM_in/WB_in       control bundles {Aluop,Alusrc} {memread,memwrite,
//                              branch} {memtoreg,regwrite}
//     register1/2, loadreg     rs1, rs2, rd of the ID instruction
//     immgenout, instruction,
//     regdata1, regdata2       ID data
//     valid_out, EX_out, MEM_out, WB_out, outreg1, outreg2, Loadregout,
//     imm, instruc_out, data1, data2     stored copies of the above
//     load_use_hazard          stall request to IF/ID (combinational)
//     bubble_count             bubbles written, saturating; present only when
//                              ID_EX_BUBBLE_COUNT_EN is defined
//
//   Update priority on each rising edge: rst > flush > stall > load.
// ---------------------------------------------------------------------------
module id_ex_pipe_reg #(
  parameter int N  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          valid_in,
  input  logic [2:0]    EX_in,
  input  logic [2:0]    MEM_in,
  input  logic [1:0]    WB_in,
  input  logic [RW-1:0] register1,
  input  logic [RW-1:0] register2,
  input  logic [RW-1:0] loadreg,
  input  logic [N-1:0]  immgenout,
  input  logic [N-1:0]  instruction,
  input  logic [N-1:0]  regdata1,
  input  logic [N-1:0]  regdata2,
  output logic          valid_out,
  output logic [2:0]    EX_out,
  output logic [2:0]    MEM_out,
  output logic [1:0]    WB_out,
  output logic [RW-1:0] outreg1,
  output logic [RW-1:0] outreg2,
  output logic [RW-1:0] Loadregout,
  output logic [N-1:0]  imm,
  output logic [N-1:0]  instruc_out,
  output logic [N-1:0]  data1,
  output logic [N-1:0]  data2,
  output logic          load_use_hazard
`ifdef ID_EX_BUBBLE_COUNT_EN
  ,
  output logic [15:0]   bubble_count
`endif
);

  // addi x0, x0, 0 -- canonical NOP, resized to the datapath width
  localparam logic [N-1:0] NOP_INSTR = N'(32'h0000_0013);

  logic          vld_p1;
  logic [2:0]    ex_p1;
  logic [2:0]    mem_p1;
  logic [1:0]    wb_p1;
  logic [RW-1:0] rs1_p1;
  logic [RW-1:0] rs2_p1;
  logic [RW-1:0] rd_p1;
  logic [N-1:0]  imm_p1;
  logic [N-1:0]  instr_p1;
  logic [N-1:0]  data1_p1;
  logic [N-1:0]  data2_p1;

  // ---- ID -> EX stage boundary ----
  // Reset and flush both leave a clean bubble, so they share one branch;
  // only the bubble counter tells them apart.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld_p1   <= 1'b0;
      ex_p1    <= '0;
      mem_p1   <= '0;
      wb_p1    <= '0;
      rs1_p1   <= '0;
      rs2_p1   <= '0;
      rd_p1    <= '0;
      imm_p1   <= '0;
      instr_p1 <= NOP_INSTR;
      data1_p1 <= '0;
      data2_p1 <= '0;
    end else if (!stall) begin
      vld_p1   <= valid_in;
      // An invalid slot must not carry side-effecting control into EX
      ex_p1    <= valid_in ? EX_in  : 3'b000;
      mem_p1   <= valid_in ? MEM_in : 3'b000;
      wb_p1    <= valid_in ? WB_in  : 2'b00;
      rs1_p1   <= register1;
      rs2_p1   <= register2;
      rd_p1    <= loadreg;
      imm_p1   <= immgenout;
      instr_p1 <= instruction;
      data1_p1 <= regdata1;
      data2_p1 <= regdata2;
    end
  end

  assign valid_out   = vld_p1;
  assign EX_out      = ex_p1;
  assign MEM_out     = mem_p1;
  assign WB_out      = wb_p1;
  assign outreg1     = rs1_p1;
  assign outreg2     = rs2_p1;
  assign Loadregout  = rd_p1;
  assign imm         = imm_p1;
  assign instruc_out = instr_p1;
  assign data1       = data1_p1;
  assign data2       = data2_p1;

  // A load in EX whose rd feeds the ID instruction; x0 is never a real
  // dependency. Gated by valid_in so an empty ID slot never stalls fetch.
  assign load_use_hazard = valid_in && vld_p1 && mem_p1[2] && (rd_p1 != '0) &&
                           ((rd_p1 == register1) || (rd_p1 == register2));

`ifdef ID_EX_BUBBLE_COUNT_EN
  logic [15:0] bub_cnt_p1;

  // A bubble is written on flush, or on a load edge with no valid instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      bub_cnt_p1 <= '0;
    end else if (flush || (!stall && !valid_in)) begin
      if (bub_cnt_p1 != 16'hFFFF) begin
        bub_cnt_p1 <= bub_cnt_p1 + 16'd1;
      end
    end
  end

  assign bubble_count = bub_cnt_p1;
`endif

endmodule
